// File: rtl/rotl_iter_unit.sv
// rotl_iter_unit: iterative left rotator, one bit position per clock.
// Undoes the upstream right barrel rotate where area matters more than
// latency. One word is in flight at a time; the result stays on out_data
// until the consumer takes it.
module rotl_iter_unit #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [AMT_W-1:0] cnt_q,   cnt_d;

    logic accept;
    logic deliver;

    // Single-position left rotate: MSB wraps into LSB.
    function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] d);
        return {d[WIDTH-2:0], d[WIDTH-1]};
    endfunction

    assign accept  = in_valid  && (state_q == IDLE);
    assign deliver = out_ready && (state_q == DONE);

    // Handshake and status outputs decoded from state; out_data comes
    // straight from the data register, never from in_data.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_data  = data_q;
    end

    // Next-state, data and count logic.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d = in_data;
                    cnt_d  = in_amt;
                    // A zero amount needs no rotation and goes straight to DONE.
                    state_d = (in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = rotl1(data_q);
                cnt_d  = cnt_q - AMT_W'(1);
                // The cycle with cnt==1 performs the final rotate.
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (deliver) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, data and count registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rotl_iter_unit.sv
// Scoreboard bench for rotl_iter_unit (WIDTH=4): the driver pushes the
// expected word and the cycle its result must appear; an independent monitor
// checks every presented output against the queue.
module tb_rotl_iter_unit;

    localparam int W  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [AW-1:0] in_amt = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          busy;

    rotl_iter_unit #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] word;
        int           vcyc;
    } exp_t;

    exp_t   q[$];
    int     cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     n_in = 0;
    int     n_out = 0;
    int     rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit     shown = 0;
    logic [W-1:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference team right-rotate stage (plain arithmetic on a wider value).
    function automatic logic [W-1:0] rotr(input logic [W-1:0] w, input int k);
        logic [2*W-1:0] x;
        x = {w, w} >> k;
        return x[W-1:0];
    endfunction

    // Output-ready driver.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: checks latency, hold stability, and data on each transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
            if (!shown) begin
                shown = 1;
                held  = out_data;
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    chk("latency", 32'(cyc), 32'(q[0].vcyc));
                end
            end else begin
                chk("hold_stable", 32'(out_data), 32'(held));
            end
            if (out_ready) begin
                if (q.size() != 0) begin
                    chk("out_data", 32'(out_data), 32'(q[0].word));
                    void'(q.pop_front());
                end
                n_out++;
                shown = 0;
            end
        end
    end

    // Present one word, wait (bounded) for acceptance, record expectation.
    task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a, input logic [W-1:0] exp);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            q.push_back('{word: exp, vcyc: cyc + 1 + int'(a)});
            n_in++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_amt   = AW'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] orig;
        int           k;
        int           w;

        // Reset held for 3 cycles.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Amount 0: output one cycle after accept, then back to IDLE.
        rdy_mode = 0;
        send(4'b1011, 2'd0, 4'b1011);
        @(negedge clk);
        chk("amt0_valid", 32'(out_valid), 32'd1);
        chk("amt0_data", 32'(out_data), 32'b1011);
        @(negedge clk);
        chk("amt0_idle_ready", 32'(in_ready), 32'd1);
        chk("amt0_idle_valid", 32'(out_valid), 32'd0);

        // Single and wrap rotates.
        send(4'b0001, 2'd1, 4'b0010);
        drain();
        send(4'b1000, 2'd3, 4'b0100);
        drain();

        // Backpressure: result held for 5 cycles with out_ready low.
        rdy_mode = 2;
        send(4'b0110, 2'd2, 4'b1001);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'b1001);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        rdy_mode = 0;
        drain();
        @(negedge clk);
        chk("bp_idle", 32'(in_ready), 32'd1);

        // Ignored input during SHIFT.
        send(4'b0011, 2'd3, 4'b1001);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        in_amt   = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Inverse check through the right-rotate reference, random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            orig = W'($urandom);
            k    = $urandom_range(0, W - 1);
            send(rotr(orig, k), AW'(k), orig);
            if (k >= 2 && $urandom_range(0, 1) == 1) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = W'($urandom);
                in_amt   = AW'($urandom);
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        drain();
        chk("count_in_out", 32'(n_out), 32'(n_in));

        // Asynchronous reset in the middle of SHIFT.
        rdy_mode = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b0101;
        in_amt   = 2'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_arst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("arst_no_output", 32'(out_valid), 32'd0);
        end

        // Clean operation after reset.
        send(4'b1100, 2'd1, 4'b1001);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
